// File: rtl/subsurf_dma.sv
// subsurf_dma: single-channel word DMA engine with COPY, FILL and per-lane signed MIDPOINT modes.
// Define SUBSURF_DMA_ABORT_EN to add the abort_i input that cancels a running job.
//
// state   | meaning
// IDLE    | waiting for start_i; job parameters latched on acceptance
// READA   | read source word A (or the only word in COPY)
// READB   | read source word B, capture word A (MIDPOINT only)
// WRITE   | write one destination word, advance pointers and count
// DONE    | one-cycle completion pulse, then back to IDLE

module subsurf_dma #(
    parameter int AW     = 9,
    parameter int DW     = 32,
    parameter int LANE_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [AW-1:0]   src_base_i,
    input  logic [AW-1:0]   dst_base_i,
    input  logic [AW:0]     len_i,
    input  logic [DW-1:0]   fill_val_i,
`ifdef SUBSURF_DMA_ABORT_EN
    input  logic            abort_i,
`endif
    output logic            src_en_o,
    output logic [AW-1:0]   src_a_o,
    input  logic [DW-1:0]   src_do_i,
    output logic            dst_en_o,
    output logic [DW/8-1:0] dst_we_o,
    output logic [AW-1:0]   dst_a_o,
    output logic [DW-1:0]   dst_di_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int NL = DW / LANE_W;
    localparam logic [1:0] M_COPY = 2'd0;
    localparam logic [1:0] M_MID  = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_READA, S_READB, S_WRITE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic [AW-1:0]   src_ptr_q, dst_ptr_q, src_step;
    logic [AW:0]     cnt_q;
    logic [DW-1:0]   fill_q, a_q, mid_w;
    logic [LANE_W:0] lane_a, lane_b, lane_sum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Mode values 1 and 3 both behave as FILL, so bit 0 alone selects the write-only path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0)    state_d = S_DONE;
                    else if (mode_i[0]) state_d = S_WRITE;
                    else                state_d = S_READA;
                end
            end
            S_READA: state_d = (mode_q == M_MID) ? S_READB : S_WRITE;
            S_READB: state_d = S_WRITE;
            S_WRITE: begin
                if (cnt_q == (AW+1)'(1)) state_d = S_DONE;
                else if (mode_q[0])      state_d = S_WRITE;
                else                     state_d = S_READA;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SUBSURF_DMA_ABORT_EN
        if (abort_i && (state_q == S_READA || state_q == S_READB || state_q == S_WRITE))
            state_d = S_IDLE;
`endif
    end

    assign src_step = (mode_q == M_MID) ? AW'(2) : AW'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q    <= '0;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            a_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        src_ptr_q <= src_base_i;
                        dst_ptr_q <= dst_base_i;
                        cnt_q     <= len_i;
                        fill_q    <= fill_val_i;
                    end
                end
                S_READB: a_q <= src_do_i;
                S_WRITE: begin
                    dst_ptr_q <= dst_ptr_q + AW'(1);
                    src_ptr_q <= src_ptr_q + src_step;
                    cnt_q     <= cnt_q - (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Sign-extend each lane by one bit so the sum cannot overflow; dropping bit 0 is the floor halving.
    always_comb begin
        mid_w    = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        for (int i = 0; i < NL; i++) begin
            lane_a   = {a_q[i*LANE_W + LANE_W - 1], a_q[i*LANE_W +: LANE_W]};
            lane_b   = {src_do_i[i*LANE_W + LANE_W - 1], src_do_i[i*LANE_W +: LANE_W]};
            lane_sum = lane_a + lane_b;
            mid_w[i*LANE_W +: LANE_W] = lane_sum[LANE_W:1];
        end
    end

    always_comb begin
        src_en_o = 1'b0;
        src_a_o  = '0;
        dst_en_o = 1'b0;
        dst_we_o = '0;
        dst_a_o  = '0;
        dst_di_o = '0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_READA: begin
                busy_o   = 1'b1;
                src_en_o = 1'b1;
                src_a_o  = src_ptr_q;
            end
            S_READB: begin
                busy_o   = 1'b1;
                src_en_o = 1'b1;
                src_a_o  = src_ptr_q + AW'(1);
            end
            S_WRITE: begin
                busy_o   = 1'b1;
                dst_en_o = 1'b1;
                dst_we_o = '1;
                dst_a_o  = dst_ptr_q;
                if (mode_q[0])            dst_di_o = fill_q;
                else if (mode_q == M_COPY) dst_di_o = src_do_i;
                else                      dst_di_o = mid_w;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subsurf_dma.sv
// Self-checking bench for subsurf_dma: a per-cycle expected-output schedule is built from the
// mode rules for every job and compared each cycle, plus literal checks of the reference scenarios.

module tb_subsurf_dma;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  mode;
    logic [8:0]  src_base, dst_base;
    logic [9:0]  len;
    logic [31:0] fill_val;
    logic        src_en, dst_en, busy, done;
    logic [8:0]  src_a, dst_a;
    logic [31:0] src_do, dst_di;
    logic [3:0]  dst_we;
`ifdef SUBSURF_DMA_ABORT_EN
    logic        abort;
`endif

    logic [31:0] src_mem [512];
    logic [31:0] dst_mem [512];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        src_en;
        logic [8:0]  src_a;
        logic        dst_en;
        logic [3:0]  dst_we;
        logic [8:0]  dst_a;
        logic [31:0] dst_di;
    } outv_t;

    outv_t exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    done_cyc = -1;
    int    start_cyc = 0;

    always #5 clk = ~clk;

    subsurf_dma #(.AW(9), .DW(32), .LANE_W(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .mode_i     (mode),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .len_i      (len),
        .fill_val_i (fill_val),
`ifdef SUBSURF_DMA_ABORT_EN
        .abort_i    (abort),
`endif
        .src_en_o   (src_en),
        .src_a_o    (src_a),
        .src_do_i   (src_do),
        .dst_en_o   (dst_en),
        .dst_we_o   (dst_we),
        .dst_a_o    (dst_a),
        .dst_di_o   (dst_di),
        .busy_o     (busy),
        .done_o     (done)
    );

    always @(posedge clk) if (src_en) src_do <= src_mem[src_a];
    always @(posedge clk) if (dst_en && dst_we == 4'hF) dst_mem[dst_a] <= dst_di;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic outv_t sample_out();
        outv_t o;
        o.busy = busy; o.done = done; o.src_en = src_en; o.src_a = src_a;
        o.dst_en = dst_en; o.dst_we = dst_we; o.dst_a = dst_a; o.dst_di = dst_di;
        return o;
    endfunction

    // Floor of the per-lane average of two signed 16-bit lanes, in plain integer arithmetic.
    function automatic logic [31:0] mid_word(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sa, sb, s, m;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            sa = int'($signed(a[16*l +: 16]));
            sb = int'($signed(b[16*l +: 16]));
            s  = sa + sb;
            m  = (s >= 0) ? s / 2 : -((-s + 1) / 2);
            r[16*l +: 16] = m[15:0];
        end
        return r;
    endfunction

    // One clock: sample outputs 1 ns after the edge against the next scheduled expectation.
    task automatic tick();
        outv_t a, e;
        @(posedge clk);
        cyc++;
        #1;
        a = sample_out();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : outv_t'('0);
        if (!e.src_en) a.src_a = '0;
        if (!e.dst_en) begin a.dst_a = '0; a.dst_di = '0; end
        chk("cycle_outputs", 64'(a), 64'(e));
        if (done) done_cyc = cyc;
        #1;
    endtask

    task automatic push_job(input logic [1:0] m, input logic [8:0] sb, input logic [8:0] db,
                            input logic [9:0] ln, input logic [31:0] fv);
        outv_t e;
        logic [8:0] pa, pb, pd;
        for (int k = 0; k < int'(ln); k++) begin
            pd = db + 9'(k);
            if (m == 2'd0) begin
                pa = sb + 9'(k);
                e = '0; e.busy = 1'b1; e.src_en = 1'b1; e.src_a = pa; exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.dst_en = 1'b1; e.dst_we = 4'hF; e.dst_a = pd;
                e.dst_di = src_mem[pa]; exp_q.push_back(e);
            end else if (m == 2'd2) begin
                pa = sb + 9'(2*k);
                pb = sb + 9'(2*k + 1);
                e = '0; e.busy = 1'b1; e.src_en = 1'b1; e.src_a = pa; exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.src_en = 1'b1; e.src_a = pb; exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.dst_en = 1'b1; e.dst_we = 4'hF; e.dst_a = pd;
                e.dst_di = mid_word(src_mem[pa], src_mem[pb]); exp_q.push_back(e);
            end else begin
                e = '0; e.busy = 1'b1; e.dst_en = 1'b1; e.dst_we = 4'hF; e.dst_a = pd;
                e.dst_di = fv; exp_q.push_back(e);
            end
        end
        e = '0; e.done = 1'b1; exp_q.push_back(e);
    endtask

    // hold: extra cycles start stays high with scrambled parameters; poke: start raised during DONE.
    task automatic run_job(input logic [1:0] m, input logic [8:0] sb, input logic [8:0] db,
                           input logic [9:0] ln, input logic [31:0] fv, input int hold,
                           input bit poke, output int lat);
        int guard;
        push_job(m, sb, db, ln, fv);
        mode = m; src_base = sb; dst_base = db; len = ln; fill_val = fv;
        start = 1'b1; start_cyc = cyc; done_cyc = -1;
        tick();
        for (int h = 0; h < hold; h++) begin
            mode = 2'($urandom); src_base = 9'($urandom); dst_base = 9'($urandom);
            len = 10'($urandom_range(1, 9)); fill_val = $urandom;
            tick();
        end
        start = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 600) begin
            tick();
            guard++;
        end
        chk("job_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        if (poke) begin
            start = 1'b1; mode = 2'($urandom); len = 10'($urandom_range(1, 9));
            tick();
            start = 1'b0;
        end
        tick();
        lat = done_cyc - start_cyc;
    endtask

    initial begin
        int lat, per, hold;
        logic [1:0] m;
        logic [9:0] ln;
        logic [31:0] snap;

        for (int i = 0; i < 512; i++) src_mem[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; mode = '0; src_base = '0; dst_base = '0;
        len = '0; fill_val = '0;
`ifdef SUBSURF_DMA_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_outputs", 64'(sample_out()), 64'(0));
        rst_n = 1'b1;
        tick();

        chk("model_midpoint", 64'(mid_word(32'h0004FFFE, 32'h0002FFFB)), 64'h0003FFFC);

        for (int i = 0; i < 4; i++) src_mem[9'h010 + i] = 32'(i + 1);
        run_job(2'd0, 9'h010, 9'h100, 10'd4, 32'h0, 0, 1'b0, lat);
        chk("copy_latency", 64'(lat), 64'(9));
        for (int i = 0; i < 4; i++) chk("copy_data", 64'(dst_mem[9'h100 + i]), 64'(i + 1));

        run_job(2'd1, 9'h000, 9'h1FE, 10'd4, 32'hDEADBEEF, 0, 1'b0, lat);
        chk("fill_latency", 64'(lat), 64'(5));
        chk("fill_1fe", 64'(dst_mem[9'h1FE]), 64'hDEADBEEF);
        chk("fill_1ff", 64'(dst_mem[9'h1FF]), 64'hDEADBEEF);
        chk("fill_000", 64'(dst_mem[9'h000]), 64'hDEADBEEF);
        chk("fill_001", 64'(dst_mem[9'h001]), 64'hDEADBEEF);

        src_mem[9'h040] = 32'h0004FFFE;
        src_mem[9'h041] = 32'h0002FFFB;
        run_job(2'd2, 9'h040, 9'h080, 10'd1, 32'h0, 0, 1'b0, lat);
        chk("mid_latency", 64'(lat), 64'(4));
        chk("mid_data", 64'(dst_mem[9'h080]), 64'h0003FFFC);

        for (int mm = 0; mm < 4; mm++) begin
            run_job(2'(mm), 9'($urandom), 9'($urandom), 10'd0, $urandom, 0, 1'b1, lat);
            chk("len0_latency", 64'(lat), 64'(1));
        end

        run_job(2'd0, 9'h020, 9'h120, 10'd3, 32'h0, 3, 1'b0, lat);
        chk("held_start_latency", 64'(lat), 64'(7));
        for (int i = 0; i < 3; i++)
            chk("held_start_data", 64'(dst_mem[9'h120 + i]), 64'(src_mem[9'h020 + i]));

        for (int j = 0; j < 40; j++) begin
            m    = 2'($urandom_range(0, 3));
            ln   = (j == 7) ? 10'd20 : 10'($urandom_range(0, 6));
            per  = (m == 2'd0) ? 2 : (m == 2'd2) ? 3 : 1;
            hold = (ln >= 10'd2) ? $urandom_range(0, 1) : 0;
            run_job(m, 9'($urandom), 9'($urandom), ln, $urandom, hold, 1'($urandom), lat);
            chk("rand_latency", 64'(lat), 64'(int'(ln) * per + 1));
        end

        // Reset in the middle of a COPY: two words land, third never does, no done.
        snap = dst_mem[9'h052];
        push_job(2'd0, 9'h030, 9'h050, 10'd4, 32'h0);
        mode = 2'd0; src_base = 9'h030; dst_base = 9'h050; len = 10'd4;
        start = 1'b1; done_cyc = -1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 chk("reset_async_outputs", 64'(sample_out()), 64'(0));
        repeat (2) tick();
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("reset_no_done", 64'(done_cyc), 64'(-1));
        chk("reset_kept_w0", 64'(dst_mem[9'h050]), 64'(src_mem[9'h030]));
        chk("reset_kept_w1", 64'(dst_mem[9'h051]), 64'(src_mem[9'h031]));
        chk("reset_no_w2", 64'(dst_mem[9'h052]), 64'(snap));

`ifdef SUBSURF_DMA_ABORT_EN
        snap = dst_mem[9'h162];
        push_job(2'd0, 9'h060, 9'h160, 10'd8, 32'h0);
        mode = 2'd0; src_base = 9'h060; dst_base = 9'h160; len = 10'd8;
        start = 1'b1; done_cyc = -1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        chk("abort_busy_low", 64'(busy), 64'(0));
        repeat (20) tick();
        chk("abort_no_done", 64'(done_cyc), 64'(-1));
        chk("abort_w1", 64'(dst_mem[9'h161]), 64'(src_mem[9'h061]));
        chk("abort_no_w2", 64'(dst_mem[9'h162]), 64'(snap));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subsurf_dma.md
SUBSURF_DMA -- requirements
Module: subsurf_dma

Interface
REQ-001 Parameter AW, default 9, SHALL set the RAM address width (word addresses).
REQ-002 Parameter DW, default 32, SHALL set the data width; DW SHALL be a multiple of 8 and of LANE_W.
REQ-003 Parameter LANE_W, default 16, SHALL set the signed lane width used by MIDPOINT mode.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 mode  input  2  0=COPY, 1=FILL, 2=MIDPOINT, 3=reserved (treated as FILL).
REQ-008 src_base, dst_base  input  AW each  start word addresses; len  input  AW+1  output word count.
REQ-009 fill_val  input  DW  word written in FILL mode.
REQ-010 src_en  output  1 / src_a  output  AW / src_do  input  DW  source RAM port, 1-cycle synchronous read.
REQ-011 dst_en  output  1 / dst_we  output  DW/8 / dst_a  output  AW / dst_di  output  DW  destination RAM port.
REQ-012 busy  output  1  job in progress; done  output  1  one-cycle completion pulse.

Function
REQ-013 States: IDLE, READA, READB, WRITE, DONE.
REQ-014 On rising edge in IDLE with start=1, the block SHALL latch mode, bases, len and fill_val, and assert busy from the next cycle.
REQ-015 If latched len=0, the next state SHALL be DONE with no RAM access.
REQ-016 IDLE->READA for COPY/MIDPOINT and IDLE->WRITE for FILL/reserved.
REQ-017 READA: src_en=1, src_a=src_ptr; next state READB for MIDPOINT, else WRITE.
REQ-018 READB: src_en=1, src_a=src_ptr+1; src_do (word A) SHALL be captured into an internal register.
REQ-019 WRITE: dst_en=1, dst_we all ones, dst_a=dst_ptr; dst_di = src_do (COPY), fill_val (FILL), or per-lane floor((A+B)/2) computed in LANE_W+1 bits then arithmetic-shifted right 1 (MIDPOINT).
REQ-020 After WRITE, dst_ptr+=1, src_ptr+=1 (COPY) or +=2 (MIDPOINT), remaining count-=1; if count reaches 0 go to DONE, else READA (COPY/MIDPOINT) or WRITE (FILL).
REQ-021 Cost per output word SHALL be 2 cycles COPY, 3 MIDPOINT, 1 FILL; DONE adds 1 cycle.
REQ-022 All address pointers SHALL wrap modulo 2^AW without error.
REQ-023 In DONE, done=1 and busy=0 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT alter latched job parameters.
REQ-025 Outside READA/READB src_en=0; outside WRITE dst_en=0, dst_we=0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and set busy, done, src_en, dst_en, dst_we, src_a, dst_a, dst_di to 0, regardless of state.
REQ-027 Reset mid-job SHALL abandon the job with no done pulse; destination words already written remain.

Configuration
REQ-028 With SUBSURF_DMA_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort=1 on a rising edge while busy SHALL return to IDLE next cycle with no further writes and no done pulse.
REQ-029 Without SUBSURF_DMA_ABORT_EN, no abort port SHALL exist and jobs always run to DONE.

Verification
REQ-030 COPY, src_base=0x010, dst_base=0x100, len=4, src=1..4 -> dst[0x100..0x103]=1..4, done 9 cycles after busy rises.
REQ-031 FILL, dst_base=0x1FE, len=4, fill_val=0xDEADBEEF -> writes at 0x1FE,0x1FF,0x000,0x001; done 5 cycles after busy.
REQ-032 MIDPOINT, LANE_W=16, src={0x0004FFFE, 0x0002FFFB}, len=1 -> dst word 0x0003FFFC (lanes 3, -4).
REQ-033 len=0 any mode -> no src_en/dst_en pulses, done pulses one cycle after busy rises.
REQ-034 start held high during COPY len=3 with changed bases -> original job completes unchanged; rst_n low mid-job -> all outputs 0 immediately, no done.
REQ-035 With SUBSURF_DMA_ABORT_EN, abort after 2nd write of COPY len=8 -> exactly 2 writes, busy=0 next cycle, done never asserted.
